// File: rtl/tl_pkg.sv
// Shared types and helpers for the N-way traffic-light controller.
// States, timer sizing and the rotating next-way search.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_ARED,
    ST_GRN,
    ST_YLW,
    ST_FLASH
  } tl_state_e;

  localparam int MAX_WAYS = 8;
  localparam int IW       = 3;

  function automatic int tmr_w(
    input int gmax,
    input int ylw,
    input int ared
  );
    int m;
    m = gmax;
    if (ylw > m) m = ylw;
    if (ared > m) m = ared;
    return $clog2(m + 1);
  endfunction

  localparam int TW_DEF = tmr_w(12, 3, 1);

  // First latched way after cur, wrapping; way 0 is the fallback.
  function automatic logic [IW-1:0] next_way(
    input logic [MAX_WAYS-1:0] dl,
    input logic [IW-1:0]       cur,
    input int                  n
  );
    logic [IW-1:0] w;
    int idx;
    w = '0;
    for (int k = MAX_WAYS - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % n;
      if (k < n && dl[idx]) w = IW'(idx);
    end
    return w;
  endfunction

endpackage

// File: rtl/tl_prescaler.sv
// Timing-tick generator: one tick every PRESCALE clocks,
// or every clock when TEST bypasses the divider.
module tl_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic CK,
  input  logic CLRN,
  input  logic TEST,
  output logic TICK
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign TICK = TEST | (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (TEST || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tl_ctrl_nway.sv
// N-approach traffic-light controller: min/max green, demand
// latching, yellow, all-red clearance and flashing mode.
module tl_ctrl_nway
  import tl_pkg::*;
#(
  parameter int N_WAYS    = 2,
  parameter int PRESCALE  = 16,
  parameter int T_GRN_MIN = 4,
  parameter int T_GRN_MAX = 12,
  parameter int T_YLW     = 3,
  parameter int T_ALLRED  = 1
) (
  input  logic                      CK,
  input  logic                      CLRN,
  input  logic                      TEST,
  input  logic                      FLASH,
  input  logic [N_WAYS-1:0]         DEMAND,
  output logic [N_WAYS-1:0]         GRN,
  output logic [N_WAYS-1:0]         YLW,
  output logic [N_WAYS-1:0]         RED,
  output logic [$clog2(N_WAYS)-1:0] CUR_WAY
);

  localparam int WW = $clog2(N_WAYS);
  localparam int TW = tmr_w(T_GRN_MAX, T_YLW, T_ALLRED);
  localparam logic [TW:0]   G_MIN  = (TW+1)'(T_GRN_MIN);
  localparam logic [TW:0]   G_MAX  = (TW+1)'(T_GRN_MAX);
  localparam logic [TW-1:0] L_YLW  = TW'(T_YLW);
  localparam logic [TW-1:0] L_ARED = TW'(T_ALLRED);
  localparam logic [TW-1:0] L_ONE  = TW'(1);
  localparam logic [N_WAYS-1:0] W0 = N_WAYS'(1);

  tl_state_e st_q, st_d;
  logic [TW-1:0] tm_q, tm_d;
  logic [TW:0] el1;
  logic [WW-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic [N_WAYS-1:0] dl_q, dl_d, dle, oth, oh, clr;
  logic [N_WAYS-1:0] grn_q, grn_d, ylw_q, ylw_d, red_q, red_d;
  logic fl_q, fl_d;
  logic tick, pend;

  tl_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .CK  (CK),
    .CLRN(CLRN),
    .TEST(TEST),
    .TICK(tick)
  );

  always_comb begin
    st_d  = st_q;
    tm_d  = tm_q;
    cur_d = cur_q;
    nxt_d = nxt_q;
    fl_d  = fl_q;
    dle   = dl_q | W0;
    oth   = dle;
    oth[cur_q] = 1'b0;
    pend  = |oth;
    el1   = {1'b0, tm_q} + (TW+1)'(1);
    if (tick) begin
      unique case (st_q)
        ST_GRN: begin
          if ((pend && el1 >= G_MIN &&
               (!DEMAND[cur_q] || el1 >= G_MAX)) ||
              (FLASH && el1 >= G_MIN)) begin
            st_d = ST_YLW;
            tm_d = L_YLW;
          end else if (el1 >= G_MAX) begin
            tm_d = G_MAX[TW-1:0];
          end else begin
            tm_d = el1[TW-1:0];
          end
        end
        ST_YLW: begin
          if (tm_q <= L_ONE) begin
            st_d  = ST_ARED;
            tm_d  = L_ARED;
            nxt_d = WW'(next_way(MAX_WAYS'(dle),
                                 IW'(cur_q), N_WAYS));
          end else begin
            tm_d = tm_q - L_ONE;
          end
        end
        ST_ARED: begin
          if (tm_q <= L_ONE) begin
            if (FLASH) begin
              st_d = ST_FLASH;
              fl_d = 1'b1;
            end else begin
              st_d  = ST_GRN;
              cur_d = nxt_q;
              tm_d  = '0;
            end
          end else begin
            tm_d = tm_q - L_ONE;
          end
        end
        ST_FLASH: begin
          if (!FLASH) begin
            st_d  = ST_ARED;
            tm_d  = L_ARED;
            nxt_d = '0;
          end else begin
            fl_d = !fl_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Lamps are registered from the next state so they move with it.
  always_comb begin
    oh    = W0 << cur_d;
    clr   = (st_d == ST_GRN && st_q != ST_GRN) ? oh : '0;
    dl_d  = (dl_q | (DEMAND & ~grn_q)) & ~clr;
    grn_d = '0;
    ylw_d = '0;
    red_d = '1;
    unique case (st_d)
      ST_GRN: begin
        grn_d = oh;
        red_d = ~oh;
      end
      ST_YLW: begin
        ylw_d = oh;
        red_d = ~oh;
      end
      ST_FLASH: begin
        ylw_d = fl_d ? W0 : '0;
        red_d = fl_d ? ~W0 : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      st_q  <= ST_ARED;
      tm_q  <= L_ARED;
      cur_q <= '0;
      nxt_q <= '0;
      fl_q  <= 1'b0;
      dl_q  <= '0;
      grn_q <= '0;
      ylw_q <= '0;
      red_q <= '1;
    end else begin
      st_q  <= st_d;
      tm_q  <= tm_d;
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      fl_q  <= fl_d;
      dl_q  <= dl_d;
      grn_q <= grn_d;
      ylw_q <= ylw_d;
      red_q <= red_d;
    end
  end

  assign GRN     = grn_q;
  assign YLW     = ylw_q;
  assign RED     = red_q;
  assign CUR_WAY = cur_q;

endmodule

// File: tb/tb_tl_ctrl_nway.sv
// Bench for tl_ctrl_nway: directed scenarios plus random traffic
// checked against a phase-level behavioural model.
module tb_tl_ctrl_nway;

  localparam int NW   = 2;
  localparam int PRE  = 16;
  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int TY   = 3;
  localparam int TA   = 1;

  logic ck = 1'b0;
  logic clrn, test, flash;
  logic [1:0] dem, grn, ylw, red;
  logic cw;
  logic [6:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0=all-red 1=green 2=yellow 3=flash
  int m_ph, m_cnt, m_way, m_nxt, m_pc;
  bit m_on;
  bit m_dl [NW];

  tl_ctrl_nway #(
    .N_WAYS   (NW),
    .PRESCALE (PRE),
    .T_GRN_MIN(GMIN),
    .T_GRN_MAX(GMAX),
    .T_YLW    (TY),
    .T_ALLRED (TA)
  ) dut (
    .CK     (ck),
    .CLRN   (clrn),
    .TEST   (test),
    .FLASH  (flash),
    .DEMAND (dem),
    .GRN    (grn),
    .YLW    (ylw),
    .RED    (red),
    .CUR_WAY(cw)
  );

  always #5 ck = ~ck;

  assign obs = {grn, ylw, red, cw};

  task automatic m_reset();
    m_ph = 0; m_cnt = 0; m_way = 0;
    m_nxt = 0; m_pc = 0; m_on = 0;
    for (int i = 0; i < NW; i++) m_dl[i] = 0;
  endtask

  task automatic m_edge();
    bit tk, pend, found;
    bit od [NW];
    int e, oph, oway, w;
    tk = test || (m_pc == PRE - 1);
    m_pc = (test || m_pc == PRE - 1) ? 0 : m_pc + 1;
    od = m_dl; oph = m_ph; oway = m_way;
    if (tk) begin
      case (m_ph)
        1: begin
          e = m_cnt + 1;
          pend = 0;
          for (int j = 0; j < NW; j++)
            if (j != m_way && (j == 0 || od[j])) pend = 1;
          if ((pend && e >= GMIN && (!dem[m_way] || e >= GMAX)) ||
              (flash && e >= GMIN)) begin
            m_ph = 2; m_cnt = 0;
          end else m_cnt = (e > GMAX) ? GMAX : e;
        end
        2: begin
          m_cnt++;
          if (m_cnt == TY) begin
            m_ph = 0; m_cnt = 0; m_nxt = 0; found = 0;
            for (int k = 1; k < NW; k++) begin
              w = (m_way + k) % NW;
              if (!found && (w == 0 || od[w])) begin
                m_nxt = w; found = 1;
              end
            end
          end
        end
        0: begin
          m_cnt++;
          if (m_cnt == TA) begin
            m_cnt = 0;
            if (flash) begin m_ph = 3; m_on = 1; end
            else begin m_ph = 1; m_way = m_nxt; end
          end
        end
        default: begin
          if (!flash) begin m_ph = 0; m_cnt = 0; m_nxt = 0; end
          else m_on = !m_on;
        end
      endcase
    end
    for (int i = 0; i < NW; i++)
      if (dem[i] && !(oph == 1 && oway == i)) m_dl[i] = 1;
    if (m_ph == 1 && oph != 1) m_dl[m_way] = 0;
  endtask

  function automatic logic [6:0] m_exp();
    logic [1:0] g, y, r;
    g = 2'b00; y = 2'b00; r = 2'b11;
    case (m_ph)
      1: begin g[m_way] = 1'b1; r = ~g; end
      2: begin y[m_way] = 1'b1; r = ~y; end
      3: begin y[0] = m_on; r = m_on ? 2'b10 : 2'b00; end
      default: ;
    endcase
    return {g, y, r, 1'(m_way)};
  endfunction

  task automatic cyc();
    @(posedge ck);
    if (!clrn) m_reset();
    else m_edge();
    @(negedge ck);
  endtask

  task automatic test_reset();
    clrn = 0; test = 1; flash = 0; dem = 0;
    m_reset();
    #12;
    n_cmp++;
    if (obs !== 7'b00_00_11_0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", obs, 7'b00_00_11_0);
    end
    @(negedge ck);
    clrn = 1;
    cyc();
    n_cmp++;
    if (obs !== m_exp() || grn !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_first_green: got %b want %b", obs, m_exp());
    end
  endtask

  task automatic test_rest();
    int g = 0;
    repeat (100) begin
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        $display("FAIL rest: got %b want %b", obs, m_exp());
      end
      if (grn == 2'b01 && ylw == 2'b00 && cw == 1'b0) g++;
    end
    n_cmp++;
    if (g !== 100) begin
      n_bad++;
      $display("FAIL rest_count: got %0d want 100", g);
    end
  endtask

  task automatic test_demand_pulse();
    int ng = 0, ny = 0;
    dem = 2'b10;
    cyc();
    dem = 2'b00;
    repeat (20) begin
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        $display("FAIL pulse: got %b want %b", obs, m_exp());
      end
      if (grn == 2'b10) ng++;
      if (ylw == 2'b01) ny++;
    end
    n_cmp++;
    if (ng !== GMIN || ny !== TY) begin
      n_bad++;
      $display("FAIL pulse_len: got g1=%0d y0=%0d want %0d %0d",
               ng, ny, GMIN, TY);
    end
  endtask

  task automatic test_max_green();
    int run = 0;
    bit done = 0;
    dem = 2'b10;
    repeat (40) begin
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        $display("FAIL maxgrn: got %b want %b", obs, m_exp());
      end
      if (grn == 2'b10 && !done) run++;
      else if (run > 0) done = 1;
    end
    dem = 2'b00;
    repeat (40) begin
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        $display("FAIL maxgrn_settle: got %b want %b", obs, m_exp());
      end
    end
    n_cmp++;
    if (run !== GMAX) begin
      n_bad++;
      $display("FAIL maxgrn_len: got %0d want %0d", run, GMAX);
    end
  endtask

  task automatic test_flash();
    logic [5:0] tab [12] = '{
      6'b00_01_10, 6'b00_01_10, 6'b00_01_10, 6'b00_00_11,
      6'b00_01_10, 6'b00_00_00, 6'b00_01_10, 6'b00_00_00,
      6'b00_01_10, 6'b00_00_00, 6'b00_01_10, 6'b00_00_00};
    n_cmp++;
    if (grn !== 2'b01) begin
      n_bad++;
      $display("FAIL flash_pre: got %b want 01", grn);
    end
    repeat (5) cyc();
    flash = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_cmp++;
      if (obs[6:1] !== tab[i] || obs !== m_exp()) begin
        n_bad++;
        $display("FAIL flash_seq[%0d]: got %b want %b",
                 i, obs[6:1], tab[i]);
      end
    end
    flash = 0;
    cyc();
    n_cmp++;
    if (obs[6:1] !== 6'b00_00_11) begin
      n_bad++;
      $display("FAIL flash_exit_red: got %b want 000011", obs[6:1]);
    end
    cyc();
    n_cmp++;
    if (obs !== 7'b01_00_10_0) begin
      n_bad++;
      $display("FAIL flash_exit_grn: got %b want 0100100", obs);
    end
  endtask

  task automatic test_prescale();
    int ny = 0, nr = 0, ng = 0;
    test = 0;
    dem = 2'b10;
    cyc();
    dem = 2'b00;
    repeat (260) begin
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        $display("FAIL prescale: got %b want %b", obs, m_exp());
      end
      if (ylw == 2'b01) ny++;
      if (grn == 2'b10) ng++;
      if (grn == 2'b00 && ylw == 2'b00 && red == 2'b11) nr++;
    end
    n_cmp++;
    if (ny !== TY * PRE || nr !== 2 * TA * PRE || ng !== GMIN * PRE) begin
      n_bad++;
      $display("FAIL prescale_len: got y=%0d r=%0d g=%0d want %0d %0d %0d",
               ny, nr, ng, TY * PRE, 2 * TA * PRE, GMIN * PRE);
    end
    test = 1;
  endtask

  task automatic test_async_reset();
    int k = 0, g = 0;
    dem = 2'b10;
    cyc();
    dem = 2'b00;
    while (ylw !== 2'b01 && k < 10) begin
      cyc();
      k++;
    end
    n_cmp++;
    if (ylw !== 2'b01) begin
      n_bad++;
      $display("FAIL arst_wait: got %b want 01 (timeout)", ylw);
    end
    #3;
    clrn = 0;
    m_reset();
    #1;
    n_cmp++;
    if (obs !== 7'b00_00_11_0) begin
      n_bad++;
      $display("FAIL arst_now: got %b want 0000110", obs);
    end
    cyc();
    cyc();
    clrn = 1;
    cyc();
    n_cmp++;
    if (obs !== 7'b01_00_10_0 || obs !== m_exp()) begin
      n_bad++;
      $display("FAIL arst_release: got %b want 0100100", obs);
    end
    repeat (20) begin
      cyc();
      if (grn == 2'b01) g++;
    end
    n_cmp++;
    if (g !== 20) begin
      n_bad++;
      $display("FAIL arst_latch_clr: got %0d want 20", g);
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) dem = 2'($urandom);
      if ($urandom_range(0, 149) == 0) flash = !flash;
      if ($urandom_range(0, 399) == 0) test = !test;
      cyc();
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++;
        if (n_bad < 30)
          $display("FAIL random: got %b want %b", obs, m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rest();
    test_demand_pulse();
    test_max_green();
    test_flash();
    test_prescale();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
